// File: rtl/billiard_pkg.sv
// Shared constants, FSM states and rack layout for the billiard ball engine.
// Positions are top-left pixel coordinates with FRAC_BITS of sub-pixel precision.
package billiard_pkg;

    localparam int NUM_BALLS   = 11;
    localparam int FRAC_BITS   = 6;
    localparam int FRICTION    = 1;
    localparam int X_MIN       = 32;
    localparam int X_MAX       = 608;
    localparam int Y_MIN       = 32;
    localparam int Y_MAX       = 448;
    localparam int CUE_SPAWN_X = 160;
    localparam int CUE_SPAWN_Y = 232;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    // Cue ball at the spawn point, object balls in a four-column triangle.
    function automatic logic [10:0] rack_x(input int i);
        case (i)
            1:        return 11'd440;
            2, 3:     return 11'd458;
            4, 5, 6:  return 11'd476;
            7, 8, 9,
            10:       return 11'd494;
            default:  return 11'(CUE_SPAWN_X);
        endcase
    endfunction

    function automatic logic [10:0] rack_y(input int i);
        case (i)
            1, 5:     return 11'd232;
            2:        return 11'd223;
            3:        return 11'd241;
            4:        return 11'd214;
            6:        return 11'd250;
            7:        return 11'd205;
            8:        return 11'd223;
            9:        return 11'd241;
            10:       return 11'd259;
            default:  return 11'(CUE_SPAWN_Y);
        endcase
    endfunction

endpackage

// File: rtl/ball_step.sv
// One-ball combinational update: move, reflect off the cushions, then apply
// friction. Shared by every ball through the sweep index in ball_motion.
module ball_step #(
    parameter int FRAC_BITS = billiard_pkg::FRAC_BITS,
    parameter int FRICTION  = billiard_pkg::FRICTION,
    parameter int X_MIN     = billiard_pkg::X_MIN,
    parameter int X_MAX     = billiard_pkg::X_MAX,
    parameter int Y_MIN     = billiard_pkg::Y_MIN,
    parameter int Y_MAX     = billiard_pkg::Y_MAX
) (
    input  logic [10+FRAC_BITS:0] pos_x,
    input  logic [10+FRAC_BITS:0] pos_y,
    input  logic signed [31:0]    vel_x,
    input  logic signed [31:0]    vel_y,
    output logic [10+FRAC_BITS:0] next_pos_x,
    output logic [10+FRAC_BITS:0] next_pos_y,
    output logic signed [31:0]    next_vel_x,
    output logic signed [31:0]    next_vel_y
);

    localparam int PW = 11 + FRAC_BITS;
    localparam logic [PW-1:0] XLO = PW'(X_MIN << FRAC_BITS);
    localparam logic [PW-1:0] XHI = PW'(X_MAX << FRAC_BITS);
    localparam logic [PW-1:0] YLO = PW'(Y_MIN << FRAC_BITS);
    localparam logic [PW-1:0] YHI = PW'(Y_MAX << FRAC_BITS);

    function automatic logic signed [31:0] drag(input logic signed [31:0] v);
        if (v > FRICTION) return v - FRICTION;
        if (v < -FRICTION) return v + FRICTION;
        return '0;
    endfunction

    // 33-bit signed sum so a large velocity can never wrap the position.
    function automatic logic [PW+31:0] axis(
        input logic [PW-1:0]     p,
        input logic signed [31:0] v,
        input logic [PW-1:0]     lo,
        input logic [PW-1:0]     hi
    );
        logic signed [32:0] sum;
        logic [PW-1:0]      np;
        logic signed [31:0] nv;
        sum = $signed(33'(p)) + 33'(v);
        if (sum < $signed(33'(lo))) begin
            np = lo;
            nv = (v < 0) ? -v : v;
        end else if (sum > $signed(33'(hi))) begin
            np = hi;
            nv = (v > 0) ? -v : v;
        end else begin
            np = sum[PW-1:0];
            nv = v;
        end
        return {np, drag(nv)};
    endfunction

    always_comb begin
        {next_pos_x, next_vel_x} = axis(pos_x, vel_x, XLO, XHI);
        {next_pos_y, next_vel_y} = axis(pos_y, vel_y, YLO, YHI);
    end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball physics: sweeps every ball once per startOfFrame through a
// single shared ball_step, and handles collisions, potting, respawn and shots.
module ball_motion
    import billiard_pkg::*;
#(
    parameter int NUM_BALLS   = billiard_pkg::NUM_BALLS,
    parameter int FRAC_BITS   = billiard_pkg::FRAC_BITS,
    parameter int FRICTION    = billiard_pkg::FRICTION,
    parameter int X_MIN       = billiard_pkg::X_MIN,
    parameter int X_MAX       = billiard_pkg::X_MAX,
    parameter int Y_MIN       = billiard_pkg::Y_MIN,
    parameter int Y_MAX       = billiard_pkg::Y_MAX,
    parameter int CUE_SPAWN_X = billiard_pkg::CUE_SPAWN_X,
    parameter int CUE_SPAWN_Y = billiard_pkg::CUE_SPAWN_Y
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            startOfFrame,
    input  logic [NUM_BALLS-1:0]            collisions,
    input  logic signed [31:0]              newVelocitiesX [NUM_BALLS],
    input  logic signed [31:0]              newVelocitiesY [NUM_BALLS],
    input  logic [NUM_BALLS-1:0]            ball_scored,
    input  logic                            shot_valid,
    input  logic signed [31:0]              shot_velX,
    input  logic signed [31:0]              shot_velY,
    output logic signed [31:0]              velocitiesX [NUM_BALLS],
    output logic signed [31:0]              velocitiesY [NUM_BALLS],
    output logic [0:NUM_BALLS-1][10:0]      topLeftXs,
    output logic [0:NUM_BALLS-1][10:0]      topLeftYs,
    output logic [NUM_BALLS-1:0]            ball_active,
    output logic                            busy,
    output logic                            shot_ack
);

    localparam int PW = 11 + FRAC_BITS;
    localparam int IW = $clog2(NUM_BALLS);
    localparam logic [IW-1:0] LAST = IW'(NUM_BALLS - 1);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic [PW-1:0]   pos_x [NUM_BALLS];
    logic [PW-1:0]   pos_y [NUM_BALLS];
    logic [PW-1:0]   step_px;
    logic [PW-1:0]   step_py;
    logic signed [31:0] step_vx;
    logic signed [31:0] step_vy;
    logic            all_zero;
    logic            all_still;
    logic            step_en;
    logic            shot_take;
    logic            respawn;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (startOfFrame) state_next = SWEEP;
            SWEEP:   if (idx == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        step_en   = (state == SWEEP) && ball_active[idx];
        shot_take = (state == IDLE) && shot_valid && all_zero
                    && ball_active[0];
        respawn   = (state == IDLE) && !ball_active[0] && all_still;
    end

    // all_zero gates shots; all_still (active balls only) gates respawn.
    always_comb begin
        all_zero  = 1'b1;
        all_still = 1'b1;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (velocitiesX[i] != 0 || velocitiesY[i] != 0) begin
                all_zero = 1'b0;
                if (ball_active[i]) all_still = 1'b0;
            end
        end
    end

    ball_step #(
        .FRAC_BITS (FRAC_BITS),
        .FRICTION  (FRICTION),
        .X_MIN     (X_MIN),
        .X_MAX     (X_MAX),
        .Y_MIN     (Y_MIN),
        .Y_MAX     (Y_MAX)
    ) u_step (
        .pos_x      (pos_x[idx]),
        .pos_y      (pos_y[idx]),
        .vel_x      (velocitiesX[idx]),
        .vel_y      (velocitiesY[idx]),
        .next_pos_x (step_px),
        .next_pos_y (step_py),
        .next_vel_x (step_vx),
        .next_vel_y (step_vy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            busy        <= 1'b0;
            shot_ack    <= 1'b0;
            ball_active <= '1;
            for (int i = 0; i < NUM_BALLS; i++) begin
                pos_x[i]       <= PW'({rack_x(i), {FRAC_BITS{1'b0}}});
                pos_y[i]       <= PW'({rack_y(i), {FRAC_BITS{1'b0}}});
                velocitiesX[i] <= '0;
                velocitiesY[i] <= '0;
            end
        end else begin
            idx      <= (state == SWEEP && idx != LAST) ? idx + 1'b1 : '0;
            busy     <= (state_next != IDLE);
            shot_ack <= shot_take;
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (step_en && idx == IW'(i)) begin
                    pos_x[i]       <= step_px;
                    pos_y[i]       <= step_py;
                    velocitiesX[i] <= step_vx;
                    velocitiesY[i] <= step_vy;
                end
                if (collisions[i]) begin
                    velocitiesX[i] <= newVelocitiesX[i];
                    velocitiesY[i] <= newVelocitiesY[i];
                end
            end
            if (shot_take) begin
                velocitiesX[0] <= shot_velX;
                velocitiesY[0] <= shot_velY;
            end
            if (respawn) begin
                ball_active[0] <= 1'b1;
                pos_x[0]       <= PW'(CUE_SPAWN_X << FRAC_BITS);
                pos_y[0]       <= PW'(CUE_SPAWN_Y << FRAC_BITS);
                velocitiesX[0] <= '0;
                velocitiesY[0] <= '0;
            end
            // Potting overrides everything else touching the ball this cycle.
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (ball_scored[i]) begin
                    ball_active[i] <= 1'b0;
                    velocitiesX[i] <= '0;
                    velocitiesY[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BALLS; i++) begin
            topLeftXs[i] = pos_x[i][PW-1:FRAC_BITS];
            topLeftYs[i] = pos_y[i][PW-1:FRAC_BITS];
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: expectations are queued with the stimulus
// and drained once the DUT settles (after a collision edge or a finished sweep).
module tb_ball_motion;

    localparam int NB = 11;
    localparam int F_X = 0, F_Y = 1, F_VX = 2, F_VY = 3;
    localparam int F_ACT = 4, F_ACTV = 5, F_BUSY = 6, F_ACK = 7;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   startOfFrame;
    logic [NB-1:0]          collisions;
    logic signed [31:0]     nvx [NB];
    logic signed [31:0]     nvy [NB];
    logic [NB-1:0]          ball_scored;
    logic                   shot_valid;
    logic signed [31:0]     shot_velX;
    logic signed [31:0]     shot_velY;
    logic signed [31:0]     velocitiesX [NB];
    logic signed [31:0]     velocitiesY [NB];
    logic [0:NB-1][10:0]    topLeftXs;
    logic [0:NB-1][10:0]    topLeftYs;
    logic [NB-1:0]          ball_active;
    logic                   busy;
    logic                   shot_ack;

    typedef struct {
        string tag;
        int    field;
        int    ball;
        int    value;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .collisions     (collisions),
        .newVelocitiesX (nvx),
        .newVelocitiesY (nvy),
        .ball_scored    (ball_scored),
        .shot_valid     (shot_valid),
        .shot_velX      (shot_velX),
        .shot_velY      (shot_velY),
        .velocitiesX    (velocitiesX),
        .velocitiesY    (velocitiesY),
        .topLeftXs      (topLeftXs),
        .topLeftYs      (topLeftYs),
        .ball_active    (ball_active),
        .busy           (busy),
        .shot_ack       (shot_ack)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic logic signed [31:0] observe(input int f, input int b);
        case (f)
            F_X:    return 32'(topLeftXs[b]);
            F_Y:    return 32'(topLeftYs[b]);
            F_VX:   return velocitiesX[b];
            F_VY:   return velocitiesY[b];
            F_ACT:  return 32'(ball_active[b]);
            F_ACTV: return 32'(ball_active);
            F_BUSY: return 32'(busy);
            default: return 32'(shot_ack);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int f, input int b,
                              input int v);
        exp_t e;
        e.tag = tag; e.field = f; e.ball = b; e.value = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.field, e.ball), e.value);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collide(input int b, input int vx, input int vy);
        collisions[b] = 1'b1;
        nvx[b] = vx;
        nvy[b] = vy;
        tick();
        collisions = '0;
    endtask

    task automatic wait_idle(inout int cnt);
        while (busy && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    // Returns cycles from the startOfFrame edge to busy low; optional
    // second pulse at sweep cycle 'extra' must be ignored.
    task automatic run_frame(output int cnt, input int extra);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            if (cnt == extra) startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        startOfFrame = 1'b0;
        collisions = '0;
        ball_scored = '0;
        shot_valid = 1'b0;
        shot_velX = 0;
        shot_velY = 0;
        for (int i = 0; i < NB; i++) begin
            nvx[i] = 0;
            nvy[i] = 0;
        end
        repeat (3) tick();
        reset = 1'b0;

        expect_val("rst_busy", F_BUSY, 0, 0);
        expect_val("rst_ack", F_ACK, 0, 0);
        expect_val("rst_active", F_ACTV, 0, 32'h7FF);
        expect_val("rst_x0", F_X, 0, 160);
        expect_val("rst_y0", F_Y, 0, 232);
        expect_val("rst_x3", F_X, 3, 458);
        expect_val("rst_y3", F_Y, 3, 241);
        expect_val("rst_x10", F_X, 10, 494);
        expect_val("rst_y10", F_Y, 10, 259);
        expect_val("rst_vx4", F_VX, 4, 0);
        drain();

        // Ball 3 to X=100.0, then a 2 px/frame push.
        collide(3, -22912, 0);
        expect_val("col_vx3", F_VX, 3, -22912);
        drain();
        run_frame(n, -1);
        chk("sweep_len", n, 12);
        expect_val("a_x3", F_X, 3, 100);
        expect_val("a_vx3", F_VX, 3, -22911);
        drain();
        collide(3, 128, 0);
        run_frame(n, -1);
        expect_val("a2_x3", F_X, 3, 102);
        expect_val("a2_vx3", F_VX, 3, 127);
        expect_val("a2_y3", F_Y, 3, 241);
        drain();
        collide(3, 0, 0);

        // Cue ball to 607.0, then into the right cushion.
        collide(0, 28608, 0);
        run_frame(n, -1);
        expect_val("b_x0", F_X, 0, 607);
        expect_val("b_vx0", F_VX, 0, 28607);
        drain();
        collide(0, 192, 0);
        run_frame(n, -1);
        expect_val("wall_x0", F_X, 0, 608);
        expect_val("wall_vx0", F_VX, 0, -191);
        drain();
        collide(0, 0, 0);

        // Collision on ball 2 in the very cycle the sweep reaches idx 2.
        collide(2, 64, 0);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        tick();
        collisions[2] = 1'b1;
        nvx[2] = -20;
        nvy[2] = 0;
        tick();
        collisions = '0;
        n = 3;
        wait_idle(n);
        chk("c_len", n, 12);
        expect_val("c_x2", F_X, 2, 459);
        expect_val("c_vx2", F_VX, 2, -20);
        drain();
        collide(2, 0, 0);

        // Second startOfFrame during a sweep is dropped.
        run_frame(n, 4);
        chk("ign_len", n, 12);
        tick();
        tick();
        expect_val("ign_busy", F_BUSY, 0, 0);
        drain();

        // Shot refused while ball 5 creeps, accepted once everything stops.
        collide(5, 0, 1);
        shot_valid = 1'b1;
        shot_velX = 300;
        shot_velY = 0;
        tick();
        shot_valid = 1'b0;
        expect_val("d_noack", F_ACK, 0, 0);
        expect_val("d_vx0", F_VX, 0, 0);
        drain();
        run_frame(n, -1);
        expect_val("d_vy5", F_VY, 5, 0);
        drain();
        shot_valid = 1'b1;
        tick();
        shot_valid = 1'b0;
        expect_val("d_ack", F_ACK, 0, 1);
        expect_val("d_shot_vx0", F_VX, 0, 300);
        drain();
        tick();
        expect_val("d_ack_pulse", F_ACK, 0, 0);
        drain();
        collide(0, 0, 0);

        // Pot the cue ball (beats a same-cycle collision); respawn waits for ball 7.
        collide(7, 2, 0);
        ball_scored[0] = 1'b1;
        collisions[0] = 1'b1;
        nvx[0] = 50;
        tick();
        ball_scored = '0;
        collisions = '0;
        expect_val("e_act0", F_ACT, 0, 0);
        expect_val("e_vx0", F_VX, 0, 0);
        drain();
        tick();
        expect_val("e_hold", F_ACT, 0, 0);
        drain();
        run_frame(n, -1);
        expect_val("e_vx7", F_VX, 7, 1);
        expect_val("e_wait", F_ACT, 0, 0);
        drain();
        run_frame(n, -1);
        tick();
        expect_val("e_respawn", F_ACT, 0, 1);
        expect_val("e_x0", F_X, 0, 160);
        expect_val("e_y0", F_Y, 0, 232);
        expect_val("e_vx7z", F_VX, 7, 0);
        drain();

        // Reset while the sweep sits at idx 6.
        collide(1, 640, 0);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_val("f_busy", F_BUSY, 0, 0);
        expect_val("f_x1", F_X, 1, 440);
        expect_val("f_vx1", F_VX, 1, 0);
        expect_val("f_x3", F_X, 3, 458);
        expect_val("f_x7", F_X, 7, 494);
        expect_val("f_x0", F_X, 0, 160);
        drain();
        run_frame(n, -1);
        chk("f_fresh_len", n, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
